// File: rtl/spi_cmd_sniff.sv
// Passive SD SPI-mode command sniffer: recovers 48-bit command tokens from CS/SCK/MOSI,
// checks framing and CRC7, and strobes finsh_o low for one clk on each accepted token.
module spi_cmd_sniff #(
    parameter bit CRC_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic [7:0]  cmd_dat_o,
    output logic [31:0] arg_o,
    output logic [6:0]  crc_o,
    output logic        crc_ok_o,
    output logic        finsh_o,
    output logic [7:0]  drop_cnt_o
);

    typedef enum logic [1:0] {StIdle, StHunt, StPre, StCapt} state_e;

    logic r_cs_s1, r_cs_s2;
    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_mosi_s1, r_mosi_s2;

    state_e      r_state, w_state;
    logic [5:0]  r_bit_cnt, w_bit_cnt;
    logic [44:0] r_shift, w_shift;
    logic [6:0]  r_crc, w_crc;
    logic [7:0]  r_cmd, w_cmd;
    logic [31:0] r_arg, w_arg;
    logic [6:0]  r_crc_rx, w_crc_rx;
    logic        r_crc_ok, w_crc_ok;
    logic        r_finsh, w_finsh;
    logic [7:0]  r_drop, w_drop;

    logic        w_bit_en;
    logic        w_bit;
    logic [45:0] w_shift_in;
    logic        w_crc_fb;
    logic [6:0]  w_crc_step;
    logic        w_crc_match;
    logic        w_drop_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_s1   <= 1'b0;
            r_cs_s2   <= 1'b0;
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_s3  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_cs_s1   <= spi_cs_n;
            r_cs_s2   <= r_cs_s1;
            r_sck_s1  <= spi_sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    // MOSI shares the SCK pipeline depth, so the sampled bit lines up with the detected edge.
    assign w_bit_en    = r_sck_s2 & ~r_sck_s3 & ~r_cs_s2;
    assign w_bit       = r_mosi_s2;
    assign w_shift_in  = {r_shift, w_bit};
    assign w_crc_fb    = w_bit ^ r_crc[6];
    assign w_crc_step  = {r_crc[5:0], 1'b0} ^ {3'b000, w_crc_fb, 2'b00, w_crc_fb};
    assign w_crc_match = (w_shift_in[7:1] == r_crc);

    always_comb begin
        w_state    = r_state;
        w_bit_cnt  = r_bit_cnt;
        w_shift    = r_shift;
        w_crc      = r_crc;
        w_cmd      = r_cmd;
        w_arg      = r_arg;
        w_crc_rx   = r_crc_rx;
        w_crc_ok   = r_crc_ok;
        w_finsh    = 1'b1;
        w_drop_inc = 1'b0;

        if (r_cs_s2) begin
            w_state = StIdle;
            if (r_state == StCapt) begin
                w_drop_inc = 1'b1;
            end
        end else begin
            unique case (r_state)
                StIdle: w_state = StHunt;
                StHunt: begin
                    if (w_bit_en && !w_bit) begin
                        w_state = StPre;
                    end
                end
                StPre: begin
                    // Start/transmission bits "0","1" fed through CRC7 from zero leave 0x09.
                    if (w_bit_en && w_bit) begin
                        w_state   = StCapt;
                        w_bit_cnt = 6'd2;
                        w_crc     = 7'h09;
                    end
                end
                StCapt: begin
                    if (w_bit_en) begin
                        w_shift   = w_shift_in[44:0];
                        w_bit_cnt = r_bit_cnt + 6'd1;
                        if (r_bit_cnt <= 6'd39) begin
                            w_crc = w_crc_step;
                        end
                        if (r_bit_cnt == 6'd47) begin
                            w_state = StHunt;
                            if (w_shift_in[0] && (w_crc_match || !CRC_CHECK)) begin
                                w_cmd    = {2'b01, w_shift_in[45:40]};
                                w_arg    = w_shift_in[39:8];
                                w_crc_rx = w_shift_in[7:1];
                                w_crc_ok = w_crc_match;
                                w_finsh  = 1'b0;
                            end else begin
                                w_drop_inc = 1'b1;
                            end
                        end
                    end
                end
                default: w_state = StIdle;
            endcase
        end

        w_drop = (w_drop_inc && (r_drop != 8'hFF)) ? r_drop + 8'd1 : r_drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_bit_cnt <= 6'd0;
            r_shift   <= '0;
            r_crc     <= 7'd0;
            r_cmd     <= 8'h00;
            r_arg     <= 32'd0;
            r_crc_rx  <= 7'd0;
            r_crc_ok  <= 1'b0;
            r_finsh   <= 1'b1;
            r_drop    <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_crc     <= w_crc;
            r_cmd     <= w_cmd;
            r_arg     <= w_arg;
            r_crc_rx  <= w_crc_rx;
            r_crc_ok  <= w_crc_ok;
            r_finsh   <= w_finsh;
            r_drop    <= w_drop;
        end
    end

    assign cmd_dat_o  = r_cmd;
    assign arg_o      = r_arg;
    assign crc_o      = r_crc_rx;
    assign crc_ok_o   = r_crc_ok;
    assign finsh_o    = r_finsh;
    assign drop_cnt_o = r_drop;

endmodule

// File: doc/spi_cmd_sniff.md
# spi_cmd_sniff

- Passive SD SPI-mode command sniffer.
- Watches the host's CS/SCK/MOSI lines, recovers 48-bit command tokens, checks start/transmission/end bits and CRC7, and presents command byte and argument.
- Signals each accepted token with a one-cycle low strobe on `finsh_o`.
- Sits directly upstream of the command-framing/UART-transmit controller; that controller fires on the falling edge of `finsh_o` and reads `cmd_dat_o`/`arg_o`.

## Interface
- `CRC_CHECK`, default 1: 1 = tokens with bad CRC7 are dropped; 0 = accepted, with `crc_ok_o` reporting the check result.
- `clk` input 1: system clock; must be ≥ 4× SCK frequency.
- `rst` input 1: reset, asynchronous, active-high.
- `spi_cs_n` input 1: card chip select, asynchronous to `clk`.
- `spi_sck` input 1: SPI clock, asynchronous.
- `spi_mosi` input 1: host-to-card data, asynchronous.
- `cmd_dat_o` output 8: first token byte, {start, tx, index[5:0]}, e.g. 0x40 for CMD0.
- `arg_o` output 32: token argument, MSB first.
- `crc_o` output 7: received CRC7.
- `crc_ok_o` output 1: received CRC7 matches the computed value.
- `finsh_o` output 1: idle high; low for exactly one `clk` when a token is accepted.
- `drop_cnt_o` output 8: saturating count of aborted or rejected tokens.

## Operation

**Input sampling**
- `spi_cs_n`, `spi_sck` and `spi_mosi` each pass through a 2-FF synchronizer.
- A third register on SCK gives rising-edge detect: `sck_rise = s2 & ~s3`.
- SPI mode 0: one bit is taken from synchronized MOSI on each `sck_rise` while synchronized CS is low.

**State machine**
- IDLE: entered while synchronized CS is high. On CS low -> HUNT.
- HUNT: bit 0 -> PRE; bit 1 -> stay.
- PRE: bit 1 (transmission bit) -> CAPT, bit count = 2, CRC seeded with bits "0","1"; bit 0 -> stay in PRE.
- CAPT: shift each bit into the 46-bit register.
  - CRC7 (x^7+x^3+1, init 0) runs over token bits 0..39.
  - On bit 47, evaluate the token, then -> HUNT.
- CS high in any state -> IDLE. If the state was CAPT, the token is aborted and `drop_cnt_o` increments.

**Token evaluation (bit 47)**
- Accept when end bit = 1, and when `CRC_CHECK` = 1 also when CRC matches.
- On accept, in the same clock:
  - `cmd_dat_o`, `arg_o`, `crc_o` and `crc_ok_o` are updated;
  - `finsh_o` <= 0 for one cycle.
- On reject:
  - outputs keep their previous values;
  - `finsh_o` stays 1;
  - `drop_cnt_o` increments.
- `drop_cnt_o` saturates at 0xFF.
- Outputs hold until the next accepted token; no output changes on reject or abort.

**Boundary cases**
- Tokens back-to-back with no idle bits: the bit after bit 47 is processed in HUNT.
- Response bytes on MOSI (0xFF) keep the block in HUNT.
- A 0 bit in PRE is treated as a fresh start bit.

## Timing
- Reset values:
  - `cmd_dat_o` = 0x00, `arg_o` = 0, `crc_o` = 0, `crc_ok_o` = 0;
  - `finsh_o` = 1, `drop_cnt_o` = 0;
  - state IDLE, synchronizer and edge registers cleared to 0.
- Bit latency: a MOSI bit is processed on the 3rd `clk` rising edge after the SCK rising edge at the pin (2 sync + 1 process).
- Accept latency: `finsh_o` falls at the edge that processes bit 47 and returns to 1 on the next edge. Outputs are valid at the same edge `finsh_o` falls, so the consumer sees stable data after its registered edge detect.
- Minimum spacing between `finsh_o` pulses is 48 SCK periods.
- CS high is honoured 2 `clk` after the pin edge and overrides any bit processed in that same cycle.
- Reset mid-token: the token is lost; no strobe and no count.

## Test plan
- CMD0 stream FF 40 00 00 00 00 95 FF, CS low throughout -> one `finsh_o` low pulse; `cmd_dat_o`=0x40, `arg_o`=0, `crc_o`=0x4A, `crc_ok_o`=1, `drop_cnt_o`=0.
- CMD8 48 00 00 01 AA 87, then CMD17 51 00 00 00 00 55 back-to-back -> two pulses, 48 SCK apart; second pulse gives `cmd_dat_o`=0x51, `arg_o`=0, `crc_o`=0x2A.
- CMD8 with last byte 0x86 (end bit 0) -> no pulse; outputs unchanged; `drop_cnt_o`=1.
- CMD0 with CRC byte 0x97, `CRC_CHECK`=1 -> dropped, `drop_cnt_o`+1. Same stimulus with `CRC_CHECK`=0 -> pulse with `crc_o`=0x4B, `crc_ok_o`=0.
- CS raised after 20 bits of CMD17, then full CMD0 -> `drop_cnt_o`=1, then one pulse with `cmd_dat_o`=0x40.
- `rst` asserted mid-token, then 300 bad tokens -> all outputs at reset values during `rst`; afterwards `drop_cnt_o` stops at 0xFF and `finsh_o` stays 1.
